// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_state_e : controller states
//   lsu_size_e  : access width after decoding funct3
//   lsu_req_t   : request fields held for the duration of one access
//   F3_*        : RV32 load/store width codes
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_WAIT,
        ST_ST_WORD,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_e;

    typedef struct packed {
        logic        store;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } lsu_req_t;

    // BU/HU have no store form, so on a store they fall into the
    // unknown-code bucket and behave as a word access.
    function automatic lsu_size_e lsu_size(input logic store, input logic [2:0] funct3);
        case (funct3)
            F3_B:    return SZ_B;
            F3_H:    return SZ_H;
            F3_BU:   return store ? SZ_W : SZ_B;
            F3_HU:   return store ? SZ_W : SZ_H;
            default: return SZ_W;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        case (size)
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   funct3_i, store_i : access type, decoded to a width with lsu_size()
//   addr_lo_i         : byte offset within the word
//   rword_i           : word read from memory
//   wdata_i           : store data (low bits used for B/H)
//   load_data_o       : selected lane, sign- or zero-extended
//   store_word_o      : rword_i with the store lane(s) replaced
// Half lane is chosen by addr_lo_i[1] only, so a half access with bit 0 set
// is naturally force-aligned.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    lsu_size_e   size;
    logic        zext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        size     = lsu_size(store_i, funct3_i);
        zext     = (funct3_i == F3_BU) || (funct3_i == F3_HU);
        half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (addr_lo_i)
            2'd0:    byte_sel = rword_i[7:0];
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            default: byte_sel = rword_i[31:24];
        endcase

        load_data_o  = rword_i;
        store_word_o = rword_i;
        case (size)
            SZ_B: begin
                load_data_o = zext ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                case (addr_lo_i)
                    2'd0:    store_word_o[7:0]   = wdata_i[7:0];
                    2'd1:    store_word_o[15:8]  = wdata_i[7:0];
                    2'd2:    store_word_o[23:16] = wdata_i[7:0];
                    default: store_word_o[31:24] = wdata_i[7:0];
                endcase
            end
            SZ_H: begin
                load_data_o = zext ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                if (addr_lo_i[1]) begin
                    store_word_o[31:16] = wdata_i[15:0];
                end else begin
                    store_word_o[15:0]  = wdata_i[15:0];
                end
            end
            default: begin
                load_data_o  = rword_i;
                store_word_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding initiator for a word-wide synchronous
// data memory. Byte/half stores are done as read-modify-write because the
// memory only has a word write strobe.
//   clk, reset (async, active low)
//   req_*   : request handshake from execute (req_ready high only in IDLE)
//   resp_*  : one-cycle completion pulse with extended load data / fault
//   mem_*   : memory read port (data RD_LAT cycles after address sampled)
//             and word write port
// Build option LSU_MISALIGN_TRAP_EN: misaligned accesses skip memory and
// complete with resp_fault=1. Without it they are force-aligned and
// resp_fault is tied low.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for a request, req_ready high
// ST_LD_WAIT | read address driven, counting down memory latency
// ST_ST_WORD | full-word write strobe, one cycle
// ST_RMW_RD  | reading word to merge a byte/half store into
// ST_RMW_WR  | writing merged word, one cycle
// ST_RESP    | resp_valid pulse
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [31:0]       mem_read_data,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [31:0]       mem_write_data,
    output logic              mem_write_en
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [ADDR_W-3:0] waddr_q, waddr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       word_q, word_d;
    logic              ready_en_q;
    logic [31:0]       load_data;
    logic [31:0]       store_word;
    lsu_size_e         req_size;
`ifdef LSU_MISALIGN_TRAP_EN
    logic              fault_q, fault_d;
`endif

    // ready_en_q keeps req_ready low while reset is held and for the
    // remainder of the release cycle, then high from the first clock on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            waddr_q    <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            ready_en_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            waddr_q    <= waddr_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            ready_en_q <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        waddr_d  = waddr_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        req_size = lsu_size(req_store, req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        fault_d  = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    req_d.store   = req_store;
                    req_d.funct3  = req_funct3;
                    req_d.addr_lo = req_addr[1:0];
                    req_d.wdata   = req_wdata;
                    waddr_d       = req_addr[ADDR_W-1:2];
                    // Down-counter: RD_LAT+1 cycles in the wait state covers
                    // the address-sample cycle plus the memory latency.
                    cnt_d         = 2'(RD_LAT);
`ifdef LSU_MISALIGN_TRAP_EN
                    fault_d       = 1'b0;
                    if (lsu_misaligned(req_size, req_addr[1:0])) begin
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else
`endif
                    if (!req_store) begin
                        state_d = ST_LD_WAIT;
                    end else if (req_size == SZ_W) begin
                        state_d = ST_ST_WORD;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_LD_WAIT, ST_RMW_RD: begin
                if (cnt_q == 2'd0) begin
                    word_d  = mem_read_data;
                    state_d = (state_q == ST_LD_WAIT) ? ST_RESP : ST_RMW_WR;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            ST_ST_WORD, ST_RMW_WR: state_d = ST_RESP;
            ST_RESP:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .funct3_i     (req_q.funct3),
        .store_i      (req_q.store),
        .addr_lo_i    (req_q.addr_lo),
        .rword_i      (word_q),
        .wdata_i      (req_q.wdata),
        .load_data_o  (load_data),
        .store_word_o (store_word)
    );

    // Every output is decoded from registered state, so an async reset
    // forces them all to zero immediately.
    assign req_ready      = ready_en_q && (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign mem_write_en   = (state_q == ST_ST_WORD) || (state_q == ST_RMW_WR);
    assign mem_read_addr  = ((state_q == ST_LD_WAIT) || (state_q == ST_RMW_RD)) ? {waddr_q, 2'b00} : '0;
    assign mem_write_addr = mem_write_en ? {waddr_q, 2'b00} : '0;
    assign mem_write_data = mem_write_en ? store_word : '0;

`ifdef LSU_MISALIGN_TRAP_EN
    assign resp_fault = resp_valid && fault_q;
    assign resp_rdata = (resp_valid && !req_q.store && !fault_q) ? load_data : '0;
`else
    assign resp_fault = 1'b0;
    assign resp_rdata = (resp_valid && !req_q.store) ? load_data : '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_addr;
    logic [31:0] mem_write_data;
    logic        mem_write_en;

    int checks   = 0;
    int failures = 0;

    load_store_unit #(.ADDR_W(32), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_store      (req_store),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en)
    );

    always #5 clk = ~clk;

    // Synchronous memory model: 64 words, read data RD_LAT cycles after the
    // address is sampled; pokes let the bench preload words.
    logic [31:0] mem [0:63];
    logic [31:0] rd_pipe [0:RD_LAT-1];
    logic        poke_en = 1'b0;
    logic [31:0] poke_addr = '0;
    logic [31:0] poke_data = '0;
    int          wr_total = 0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr[7:2]] <= poke_data;
        if (mem_write_en) begin
            mem[mem_write_addr[7:2]] <= mem_write_data;
            wr_total <= wr_total + 1;
        end
        rd_pipe[0] <= mem[mem_read_addr[7:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_read_data = rd_pipe[RD_LAT-1];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = addr; poke_data = data;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Results of the last transaction; latencies count negedges after the
    // accepting posedge.
    logic [31:0] r_rdata, r_waddr, r_wdata;
    logic        r_fault, r_rdy_low;
    int          r_lat, r_nwr, r_nrd, r_wr_at;

    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
        int  n;
        bit  done;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_accept", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        r_lat = 0; r_nwr = 0; r_nrd = 0; r_wr_at = 0; r_rdy_low = 1'b1;
        r_rdata = '0; r_fault = 1'b0; r_waddr = '0; r_wdata = '0;
        done = 1'b0;
        while (!done && r_lat < 20) begin
            @(negedge clk);
            r_lat++;
            if (req_ready) r_rdy_low = 1'b0;
            if (mem_write_en) begin
                r_nwr++; r_wr_at = r_lat;
                r_waddr = mem_write_addr; r_wdata = mem_write_data;
            end
            if (mem_read_addr != '0) r_nrd++;
            if (resp_valid) begin
                done = 1'b1; r_rdata = resp_rdata; r_fault = resp_fault;
            end
        end
        if (!done) check("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("resp_pulse_one_cycle", {31'b0, resp_valid}, 32'd0);
        check("ready_after_resp", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic check_load(input string tag, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] exp);
        run_req(1'b0, f3, addr, 32'h0);
        check({tag, "_data"}, r_rdata, exp);
        check({tag, "_lat"}, r_lat, RD_LAT + 2);
        check({tag, "_nowrite"}, r_nwr, 0);
        check({tag, "_fault"}, {31'b0, r_fault}, 32'd0);
    endtask

    int w0;

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_store = 1'b0;
        req_funct3 = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", {31'b0, resp_fault}, 32'd0);
        check("rst_wen", {31'b0, mem_write_en}, 32'd0);
        check("rst_raddr", mem_read_addr, 32'd0);
        check("rst_waddr", mem_write_addr, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", {31'b0, req_ready}, 32'd1);

        // LW aligned
        poke(32'h10, 32'hDEADBEEF);
        check_load("lw_10", 3'b010, 32'h10, 32'hDEADBEEF);

        // Sub-word loads from 0x80FF7F01
        poke(32'h10, 32'h80FF7F01);
        check_load("lb_13", 3'b000, 32'h13, 32'hFFFFFF80);
        check_load("lbu_13", 3'b100, 32'h13, 32'h00000080);
        check_load("lh_12", 3'b001, 32'h12, 32'hFFFF80FF);
        check_load("lhu_10", 3'b101, 32'h10, 32'h00007F01);
        check_load("lb_11", 3'b000, 32'h11, 32'h0000007F);
        check_load("lh_10", 3'b001, 32'h10, 32'h00007F01);
        check_load("unk_f3_as_w", 3'b111, 32'h10, 32'h80FF7F01);

        // SB via read-modify-write
        poke(32'h20, 32'h11223344);
        run_req(1'b1, 3'b000, 32'h21, 32'h000000AB);
        check("sb_nwr", r_nwr, 1);
        check("sb_waddr", r_waddr, 32'h20);
        check("sb_wdata", r_wdata, 32'h1122AB44);
        check("sb_rdata", r_rdata, 32'h0);
        check("sb_lat", r_lat, RD_LAT + 3);
        check("sb_mem", mem[8], 32'h1122AB44);

        // SH upper half
        poke(32'h24, 32'h11223344);
        run_req(1'b1, 3'b001, 32'h26, 32'hFFFF5566);
        check("sh_nwr", r_nwr, 1);
        check("sh_wdata", r_wdata, 32'h55663344);
        check("sh_mem", mem[9], 32'h55663344);

        // SW: strobe in the first cycle after accept, response next cycle
        run_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D);
        check("sw_nwr", r_nwr, 1);
        check("sw_wr_cycle", r_wr_at, 1);
        check("sw_lat", r_lat, 2);
        check("sw_waddr", r_waddr, 32'h30);
        check("sw_wdata", r_wdata, 32'hCAFEF00D);
        check("sw_ready_low", {31'b0, r_rdy_low}, 32'd1);
        check("sw_mem", mem[12], 32'hCAFEF00D);

        // Misaligned LW
        run_req(1'b0, 3'b010, 32'h31, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_mis_fault", {31'b0, r_fault}, 32'd1);
        check("lw_mis_rdata", r_rdata, 32'h0);
        check("lw_mis_noread", r_nrd, 0);
        check("lw_mis_nowrite", r_nwr, 0);
        check("lw_mis_lat", r_lat, 1);
`else
        check("lw_mis_fault", {31'b0, r_fault}, 32'd0);
        check("lw_mis_rdata", r_rdata, 32'hCAFEF00D);
        check("lw_mis_lat", r_lat, RD_LAT + 2);
        check("lw_mis_nowrite", r_nwr, 0);
`endif

        // Reset while SH sits in RMW_RD
        poke(32'h40, 32'hA5A5A5A5);
        w0 = wr_total;
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h42; req_wdata = 32'h00001234;
        check("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rmw_rst_in_read", mem_read_addr, 32'h40);
        #2 reset = 1'b0;
        #1;
        check("rmw_rst_raddr", mem_read_addr, 32'h0);
        check("rmw_rst_wen", {31'b0, mem_write_en}, 32'd0);
        check("rmw_rst_ready_low", {31'b0, req_ready}, 32'd0);
        check("rmw_rst_resp", {31'b0, resp_valid}, 32'd0);
        check("rmw_rst_wdata", mem_write_data, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rmw_rst_ready_after", {31'b0, req_ready}, 32'd1);
        check("rmw_rst_no_write", wr_total - w0, 0);
        check("rmw_rst_mem_kept", mem[16], 32'hA5A5A5A5);
        check_load("lw_40_after_rst", 3'b010, 32'h40, 32'hA5A5A5A5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
